match_report_queue: RTL and testbench
=====================================

// Module: match_report_queue
// PURPOSE
//  Stage directly downstream of the MATCH stage in the Aho-Corasick matcher.
//  Captures every matched state with the position of the input character that produced it.
//  Buffers each {state, position} report in a FIFO.
//  Hands reports to the host over a valid/ready interface; reports that arrive while the FIFO is full are counted as overflow.
// PARAMETERS
//  STATE_W   8   width of automaton state (matches NOW_STATE/STATE_DATA)
//  POS_W     16  width of character position counter
//  DEPTH     16  FIFO entries, power of two
//  ADDR_W    4   log2(DEPTH)
//  LAT_ADJ   2   pipeline latency from character accept to MATCH strobe, subtracted from tag
// PORTS
//  CLK         in   1        clock, all logic on rising edge
//  RST         in   1        reset, synchronous, active-low
//  CHAR_EN     in   1        one input character accepted this cycle (same strobe as EN)
//  MATCH_EN    in   1        match event strobe from MATCH stage
//  MATCH_STATE in   STATE_W  matched state (STATE_DATA of MATCH stage)
//  OUT_VALID   out  1        head report available
//  OUT_READY   in   1        host consumes head report when OUT_VALID=1
//  OUT_STATE   out  STATE_W  head report state
//  OUT_POS     out  POS_W    head report character position
//  COUNT       out  ADDR_W+1 entries held, 0..DEPTH
//  OVERFLOW    out  1        sticky: at least one report dropped
//  DROP_CNT    out  8        dropped reports, saturates at 255
//  CLR_OVF     in   1        clears OVERFLOW and DROP_CNT
// BEHAVIOUR
//  Reset (RST=0 at edge): CHAR_CNT=0, rd/wr ptr=0, COUNT=0, OUT_VALID=0,
//   OUT_STATE=0, OUT_POS=0, OVERFLOW=0, DROP_CNT=0. Reset has priority over all inputs.
//  Reset mid-operation discards all queued reports.
//  CHAR_CNT: +1 per cycle with CHAR_EN; wraps 2^POS_W-1 -> 0.
//  Tag: pos = (CHAR_CNT - LAT_ADJ) mod 2^POS_W.
//   CHAR_CNT is the value registered before this cycle's edge.
//  pop  = OUT_VALID & OUT_READY.
//  push = MATCH_EN & (COUNT<DEPTH | pop).
//  Push while full with pop in the same cycle: both occur; COUNT is unchanged and no drop is recorded.
//  drop = MATCH_EN & COUNT==DEPTH & !pop.
//   On drop: the entry is discarded, OVERFLOW<=1, and DROP_CNT<=DROP_CNT+1, saturating at 255.
//  CLR_OVF: OVERFLOW<=0 and DROP_CNT<=0.
//   If a drop occurs in the same cycle, the drop wins: OVERFLOW<=1 and DROP_CNT<=1.
//  Latency: a push into an empty FIFO raises OUT_VALID on the next cycle; there is no fall-through.
//  OUT_STATE/OUT_POS: show the head entry whenever OUT_VALID=1.
//   They are stable while OUT_VALID=1 & OUT_READY=0. They hold their last value when empty.
//  OUT_VALID == (COUNT!=0), registered.
//  Pointers are ADDR_W bits and wrap modulo DEPTH. COUNT is updated +1/-1/0 per push/pop.
//  Pop with OUT_VALID=0 is ignored; COUNT never underflows.
//  MATCH_STATE is ignored when MATCH_EN=0.
// STRUCTURE
//  ac_pkg: STATE_W and POS_W constants; typedef match_rpt_t = {state, pos}.
//  ac_pkg: the DROP_CNT width constant (8).
//  Sub-module match_fifo: generic synchronous FIFO of match_rpt_t.
//   Register array; ports push/pop/full/empty/count/head.
//  Top of this block: CHAR_CNT, tag arithmetic, push/drop decision, overflow/drop counters.
// TESTING
//  1 Reset release, idle 10 cycles -> OUT_VALID=0, COUNT=0, OVERFLOW=0, DROP_CNT=0.
//  2 5 CHAR_EN, then MATCH_EN with MATCH_STATE=0x2A, OUT_READY=0:
//    -> next cycle OUT_VALID=1, OUT_STATE=0x2A, OUT_POS=3; values held while not ready.
//  3 18 MATCH_EN pulses with no pops, DEPTH=16:
//    -> COUNT=16, OVERFLOW=1, DROP_CNT=2; 16 pops return states in order.
//  4 Full FIFO, MATCH_EN and pop in the same cycle -> COUNT stays 16, DROP_CNT unchanged.
//    The new entry appears last.
//  5 CHAR_CNT=0xFFFF, then CHAR_EN -> CHAR_CNT=0.
//    MATCH at CHAR_CNT=1 -> OUT_POS=0xFFFF (wrap).
//  6 RST=0 for 1 cycle with COUNT=7 -> COUNT=0, OUT_VALID=0.
//    CLR_OVF with a drop in the same cycle -> OVERFLOW=1, DROP_CNT=1.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared constants and types for the Aho-Corasick matcher stages.
//   STATE_W     : width of an automaton state
//   POS_W       : width of the character position counter
//   DROP_W      : width of the dropped-report counter
//   match_rpt_t : one match report, {state, pos}
package ac_pkg;

    localparam int unsigned STATE_W = 8;
    localparam int unsigned POS_W   = 16;
    localparam int unsigned DROP_W  = 8;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [POS_W-1:0]   pos;
    } match_rpt_t;

endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO of match reports built on a register array.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   push      : write push_data (accepted when not full, or when full and popping)
//   pop       : remove head entry (ignored when empty)
//   push_data : report to enqueue
//   full      : DEPTH entries held
//   empty     : registered, no entries held
//   count     : entries held, 0..DEPTH
//   head      : registered head entry; holds its last value when empty
module match_fifo
    import ac_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  match_rpt_t        push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output match_rpt_t        head
);

    localparam logic [ADDR_W-1:0] PtrOne  = 1;
    localparam logic [ADDR_W:0]   CntOne  = 1;
    localparam logic [ADDR_W:0]   CntFull = (ADDR_W+1)'(DEPTH);

    match_rpt_t        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q;
    match_rpt_t        head_q, head_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CntFull) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        // Head is registered, so forward the entry being written this cycle
        // when it lands in the slot that becomes the head.
        head_d = head_q;
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            head_q   <= head_d;
        end
    end

    assign full  = (count_q == CntFull);
    assign empty = empty_q;
    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/match_report_queue.sv
// Captures matched states from the MATCH stage, tags each with the position of
// the character that produced it, queues the reports and hands them to the host.
//   CLK, RST      : clock and synchronous active-low reset
//   CHAR_EN       : one input character accepted this cycle
//   MATCH_EN      : match strobe; MATCH_STATE is the matched state
//   OUT_VALID     : head report available
//   OUT_READY     : host consumes head report
//   OUT_STATE/POS : head report
//   COUNT         : entries held
//   OVERFLOW      : sticky, some report was dropped
//   DROP_CNT      : dropped reports, saturating
//   CLR_OVF       : clears OVERFLOW and DROP_CNT
module match_report_queue
    import ac_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned LAT_ADJ = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CHAR_EN,
    input  logic               MATCH_EN,
    input  logic [STATE_W-1:0] MATCH_STATE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [STATE_W-1:0] OUT_STATE,
    output logic [POS_W-1:0]   OUT_POS,
    output logic [ADDR_W:0]    COUNT,
    output logic               OVERFLOW,
    output logic [DROP_W-1:0]  DROP_CNT,
    input  logic               CLR_OVF
);

    localparam logic [POS_W-1:0]  PosOne  = 1;
    localparam logic [POS_W-1:0]  LatAdj  = POS_W'(LAT_ADJ);
    localparam logic [DROP_W-1:0] DropOne = 1;
    localparam logic [DROP_W-1:0] DropMax = '1;

    logic [POS_W-1:0]  char_cnt_q, char_cnt_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              full, empty;
    logic              pop, push, drop;
    match_rpt_t        rpt_in, head;

    always_comb begin
        pop  = !empty && OUT_READY;
        push = MATCH_EN && (!full || pop);
        drop = MATCH_EN && full && !pop;

        // The match strobe trails the character by LAT_ADJ cycles.
        rpt_in.state = MATCH_STATE;
        rpt_in.pos   = char_cnt_q - LatAdj;

        char_cnt_d = CHAR_EN ? char_cnt_q + PosOne : char_cnt_q;

        // A drop in the same cycle as a clear restarts the count at one.
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (CLR_OVF) begin
                drop_cnt_d = DropOne;
            end else if (drop_cnt_q != DropMax) begin
                drop_cnt_d = drop_cnt_q + DropOne;
            end
        end else if (CLR_OVF) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            char_cnt_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            char_cnt_q <= char_cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    match_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (push),
        .pop       (pop),
        .push_data (rpt_in),
        .full      (full),
        .empty     (empty),
        .count     (COUNT),
        .head      (head)
    );

    assign OUT_VALID = !empty;
    assign OUT_STATE = head.state;
    assign OUT_POS   = head.pos;
    assign OVERFLOW  = overflow_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_match_report_queue.sv
module tb_match_report_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CHAR_EN;
    logic        MATCH_EN;
    logic [7:0]  MATCH_STATE;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  OUT_STATE;
    logic [15:0] OUT_POS;
    logic [4:0]  COUNT;
    logic        OVERFLOW;
    logic [7:0]  DROP_CNT;
    logic        CLR_OVF;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    match_report_queue #(
        .DEPTH   (16),
        .ADDR_W  (4),
        .LAT_ADJ (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CHAR_EN     (CHAR_EN),
        .MATCH_EN    (MATCH_EN),
        .MATCH_STATE (MATCH_STATE),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_STATE   (OUT_STATE),
        .OUT_POS     (OUT_POS),
        .COUNT       (COUNT),
        .OVERFLOW    (OVERFLOW),
        .DROP_CNT    (DROP_CNT),
        .CLR_OVF     (CLR_OVF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled there too.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST         = 1'b0;
        CHAR_EN     = 1'b0;
        MATCH_EN    = 1'b0;
        MATCH_STATE = 8'h00;
        OUT_READY   = 1'b0;
        CLR_OVF     = 1'b0;
        step();
        step();
        RST = 1'b1;

        // Idle after reset
        repeat (10) step();
        chk("idle_valid", OUT_VALID, 0);
        chk("idle_count", COUNT, 0);
        chk("idle_ovf", OVERFLOW, 0);
        chk("idle_drop", DROP_CNT, 0);
        chk("idle_state", OUT_STATE, 0);
        chk("idle_pos", OUT_POS, 0);

        // Five characters, then a match: tag = 5 - 2 = 3
        CHAR_EN = 1'b1;
        repeat (5) step();
        CHAR_EN     = 1'b0;
        MATCH_EN    = 1'b1;
        MATCH_STATE = 8'h2A;
        step();
        MATCH_EN    = 1'b0;
        MATCH_STATE = 8'hFF;
        chk("first_valid", OUT_VALID, 1);
        chk("first_state", OUT_STATE, 8'h2A);
        chk("first_pos", OUT_POS, 16'd3);
        chk("first_count", COUNT, 1);
        repeat (3) step();
        chk("hold_valid", OUT_VALID, 1);
        chk("hold_state", OUT_STATE, 8'h2A);
        chk("hold_pos", OUT_POS, 16'd3);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        chk("drain_valid", OUT_VALID, 0);
        chk("drain_count", COUNT, 0);
        chk("drain_state_hold", OUT_STATE, 8'h2A);
        // Popping an empty queue must not underflow
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        chk("empty_pop_count", COUNT, 0);

        // 18 matches into a 16-deep queue: two drops
        MATCH_EN = 1'b1;
        for (int i = 0; i < 18; i++) begin
            MATCH_STATE = 8'h10 + 8'(i);
            step();
        end
        MATCH_EN = 1'b0;
        chk("full_count", COUNT, 16);
        chk("full_ovf", OVERFLOW, 1);
        chk("full_drop", DROP_CNT, 2);
        chk("full_head", OUT_STATE, 8'h10);

        // Push and pop together while full: no drop, new entry goes last
        MATCH_EN    = 1'b1;
        MATCH_STATE = 8'h99;
        OUT_READY   = 1'b1;
        step();
        MATCH_EN  = 1'b0;
        OUT_READY = 1'b0;
        chk("pp_count", COUNT, 16);
        chk("pp_drop", DROP_CNT, 2);
        chk("pp_head", OUT_STATE, 8'h11);

        for (int i = 0; i < 16; i++) begin
            chk("order_state", OUT_STATE, (i < 15) ? 32'h11 + 32'(i) : 32'h99);
            chk("order_pos", OUT_POS, 16'd3);
            OUT_READY = 1'b1;
            step();
            OUT_READY = 1'b0;
        end
        chk("order_empty_valid", OUT_VALID, 0);
        chk("order_empty_count", COUNT, 0);

        // Plain clear
        CLR_OVF = 1'b1;
        step();
        CLR_OVF = 1'b0;
        chk("clr_ovf", OVERFLOW, 0);
        chk("clr_drop", DROP_CNT, 0);

        // Reset mid-operation discards queued reports
        MATCH_EN    = 1'b1;
        MATCH_STATE = 8'h55;
        repeat (7) step();
        chk("pre_rst_count", COUNT, 7);
        RST = 1'b0;
        step();
        RST      = 1'b1;
        MATCH_EN = 1'b0;
        chk("rst_count", COUNT, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_state", OUT_STATE, 0);
        chk("rst_pos", OUT_POS, 0);

        // Fill, one drop, then drop coincident with clear
        MATCH_EN = 1'b1;
        repeat (17) step();
        chk("refill_drop", DROP_CNT, 1);
        CLR_OVF = 1'b1;
        step();
        CLR_OVF = 1'b0;
        chk("clr_drop_ovf", OVERFLOW, 1);
        chk("clr_drop_cnt", DROP_CNT, 1);

        // Saturation at 255
        repeat (260) step();
        MATCH_EN = 1'b0;
        chk("sat_drop", DROP_CNT, 8'hFF);
        chk("sat_count", COUNT, 16);
        CLR_OVF = 1'b1;
        step();
        CLR_OVF = 1'b0;
        chk("sat_clr_ovf", OVERFLOW, 0);
        chk("sat_clr_drop", DROP_CNT, 0);

        // Position counter wrap
        RST = 1'b0;
        step();
        RST     = 1'b1;
        CHAR_EN = 1'b1;
        repeat (65535) step();
        MATCH_EN    = 1'b1;
        MATCH_STATE = 8'hA0;
        step();
        MATCH_STATE = 8'hA1;
        step();
        CHAR_EN     = 1'b0;
        MATCH_STATE = 8'hA2;
        step();
        MATCH_EN = 1'b0;
        chk("wrap_count", COUNT, 3);
        chk("wrap0_state", OUT_STATE, 8'hA0);
        chk("wrap0_pos", OUT_POS, 16'hFFFD);
        OUT_READY = 1'b1;
        step();
        chk("wrap1_state", OUT_STATE, 8'hA1);
        chk("wrap1_pos", OUT_POS, 16'hFFFE);
        step();
        chk("wrap2_state", OUT_STATE, 8'hA2);
        chk("wrap2_pos", OUT_POS, 16'hFFFF);
        step();
        OUT_READY = 1'b0;
        chk("wrap_empty", OUT_VALID, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
